swapout_sequence_player: RTL and testbench
==========================================

SWAPOUT_SEQUENCE_PLAYER -- requirements
Module: swapout_sequence_player

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning sequence-table address width (64 entries).
REQ-002 SHALL have parameter DELAY_WIDTH, default 16, meaning per-entry pre-event delay width in clocks.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all logic is in the evgTxClk domain.
REQ-004 evgTxClk  input  1  event generator transmit clock.
REQ-005 evgTxReset  input  1  asynchronous active-high reset.
REQ-006 evgSequenceStart  input  1  single-cycle start request from the swapout sequence control stage.
REQ-007 evgSequenceAbort  input  1  level; forces return to idle.
REQ-008 tableWriteStrobe  input  1  table write enable.
REQ-009 tableWriteAddress  input  ADDR_WIDTH  table write address.
REQ-010 tableWriteData  input  8+DELAY_WIDTH  {delay, eventCode[7:0]}; eventCode 0 marks end of sequence.
REQ-011 statusClear  input  1  clears sticky faults.
REQ-012 evgEventCode  output  8  event code to transmitter.
REQ-013 evgEventValid  output  1  evgEventCode is valid.
REQ-014 evgEventReady  input  1  transmitter accepts the code this cycle.
REQ-015 sequenceBusy  output  1  high in any state other than IDLE.
REQ-016 sequenceDone  output  1  single-cycle pulse on normal completion.
REQ-017 overrunFault  output  1  sticky: start received while busy.
REQ-018 writeRejectFault  output  1  sticky: table write attempted while busy.

Function
REQ-019 SHALL hold a 2^ADDR_WIDTH x (8+DELAY_WIDTH) table with a one-cycle registered read.
REQ-020 SHALL perform a table write on a tableWriteStrobe cycle only when IDLE; otherwise the write is dropped and writeRejectFault set.
REQ-021 SHALL implement states IDLE, FETCH, READ, DELAY, EMIT.
REQ-022 IDLE: start at cycle N -> read address 0, enter FETCH at N+1.
REQ-023 FETCH: present read address; enter READ next cycle.
REQ-024 READ: code 0 -> IDLE with sequenceDone high for one cycle; else load counter with delay and go to DELAY (delay != 0) or EMIT (delay 0).
REQ-025 DELAY: decrement each cycle; at counter value 1 enter EMIT; first evgEventValid at cycle N+3+D for the entry-0 delay D.
REQ-026 EMIT: evgEventValid high and evgEventCode stable until the cycle evgEventReady is high; that cycle is the transfer.
REQ-027 On transfer: if address is 2^ADDR_WIDTH-1, go to IDLE with sequenceDone (implicit end); else increment the address and go to FETCH.
REQ-028 evgEventValid SHALL be high only in EMIT; evgEventCode SHALL be 0 outside EMIT.
REQ-029 evgSequenceStart while busy SHALL be ignored and SHALL set overrunFault; the running sequence is unaffected.
REQ-030 evgSequenceAbort high SHALL force IDLE on the next edge from any state, with no sequenceDone pulse; abort has priority over start and transfer in the same cycle.
REQ-031 statusClear SHALL clear both sticky faults; a same-cycle set wins over clear.
REQ-032 Delay counter and address SHALL never wrap silently; address wrap is handled only per REQ-027.

Reset
REQ-033 On evgTxReset: state IDLE, address 0, counter 0, evgEventValid 0, evgEventCode 0, sequenceBusy 0, sequenceDone 0, both faults 0.
REQ-034 Table contents SHALL NOT be cleared by reset; reset mid-sequence abandons it without sequenceDone.
REQ-035 Outputs SHALL be glitch-free registered values after reset deassertion.

Verification
REQ-036 Table {0:(5,0x10),1:(0,0x20),2:(0,0x00)}, ready tied high, start at N -> 0x10 valid at N+8, 0x20 valid at N+11, sequenceDone at N+13.
REQ-037 Same table, ready low for 4 cycles after 0x10 valid -> 0x10 held 5 cycles; next timing shifts by 4.
REQ-038 Start pulse while in DELAY -> overrunFault 1, sequence completes unchanged; statusClear -> overrunFault 0.
REQ-039 Abort during EMIT -> evgEventValid 0 next cycle, state IDLE, no sequenceDone; new start restarts at address 0.
REQ-040 Write while busy -> writeRejectFault 1, table entry unchanged on readback run.
REQ-041 All 64 entries nonzero, delay 0, ready high -> 64 events emitted, sequenceDone after last transfer; reset asserted mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/swapout_sequence_player.sv
// Swapout sequence player: plays a table of {delay, eventCode} entries
// to the event transmitter with a valid/ready handshake.
module swapout_sequence_player #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                         evgTxClk,
    input  logic                         evgTxReset,
    input  logic                         evgSequenceStart,
    input  logic                         evgSequenceAbort,
    input  logic                         tableWriteStrobe,
    input  logic [ADDR_WIDTH-1:0]        tableWriteAddress,
    input  logic [8+DELAY_WIDTH-1:0]     tableWriteData,
    input  logic                         statusClear,
    output logic [7:0]                   evgEventCode,
    output logic                         evgEventValid,
    input  logic                         evgEventReady,
    output logic                         sequenceBusy,
    output logic                         sequenceDone,
    output logic                         overrunFault,
    output logic                         writeRejectFault
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int DW    = 8 + DELAY_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_DELAY,
        S_EMIT
    } state_t;

    logic [DW-1:0]          table_mem [DEPTH];
    logic [DW-1:0]          rd_data_q;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic [7:0]             code_q, code_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   wrrej_q, wrrej_d;

    logic                   is_idle;
    logic                   last_addr;
    logic                   fetch_end;
    logic                   transfer;
    logic [7:0]             rd_code;
    logic [DELAY_WIDTH-1:0] rd_delay;

    assign is_idle   = (state_q == S_IDLE);
    assign last_addr = (addr_q == '1);
    assign transfer  = (state_q == S_EMIT) && evgEventReady;
    assign rd_code   = rd_data_q[7:0];
    assign rd_delay  = rd_data_q[DW-1:8];
    // End-of-sequence is decoded while fetching so the done pulse can be
    // registered and still appear during the READ cycle.
    assign fetch_end = (table_mem[addr_q][7:0] == 8'h00);

    // Sequence table: writes only while idle; registered read during FETCH.
    always_ff @(posedge evgTxClk) begin
        if (tableWriteStrobe && is_idle) begin
            table_mem[tableWriteAddress] <= tableWriteData;
        end
        if (state_q == S_FETCH) begin
            rd_data_q <= table_mem[addr_q];
        end
    end

    // Next-state, address/counter and registered-output decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        wrrej_d   = wrrej_q;

        case (state_q)
            S_IDLE: begin
                if (evgSequenceStart) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_READ;
                done_d  = fetch_end;
            end
            S_READ: begin
                if (rd_code == 8'h00) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = rd_delay;
                    state_d = (rd_delay != '0) ? S_DELAY : S_EMIT;
                end
            end
            S_DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DELAY_WIDTH'(1);
                end
                if (cnt_q <= DELAY_WIDTH'(1)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (transfer) begin
                    if (last_addr) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (evgSequenceAbort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        if (statusClear) begin
            overrun_d = 1'b0;
            wrrej_d   = 1'b0;
        end
        if (evgSequenceStart && !is_idle) begin
            overrun_d = 1'b1;
        end
        if (tableWriteStrobe && !is_idle) begin
            wrrej_d = 1'b1;
        end

        valid_d = (state_d == S_EMIT);
        code_d  = valid_d ? rd_code : '0;
        busy_d  = (state_d != S_IDLE);
    end

    // State, sequencing and registered outputs.
    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            wrrej_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            wrrej_q   <= wrrej_d;
        end
    end

    assign evgEventCode     = code_q;
    assign evgEventValid    = valid_q;
    assign sequenceBusy     = busy_q;
    assign sequenceDone     = done_q;
    assign overrunFault     = overrun_q;
    assign writeRejectFault = wrrej_q;

endmodule

// File: tb/tb_swapout_sequence_player.sv
// Scoreboard bench for swapout_sequence_player: stimulus pushes expected
// transfers/done pulses with their cycle numbers, a monitor pops and compares.
module tb_swapout_sequence_player;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wstb = 1'b0;
    logic [5:0]  waddr = '0;
    logic [23:0] wdata = '0;
    logic        clr = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  code;
    logic        valid;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        wrrej;

    swapout_sequence_player #(
        .ADDR_WIDTH  (6),
        .DELAY_WIDTH (16)
    ) dut (
        .evgTxClk          (clk),
        .evgTxReset        (rst),
        .evgSequenceStart  (start),
        .evgSequenceAbort  (abort),
        .tableWriteStrobe  (wstb),
        .tableWriteAddress (waddr),
        .tableWriteData    (wdata),
        .statusClear       (clr),
        .evgEventCode      (code),
        .evgEventValid     (valid),
        .evgEventReady     (ready),
        .sequenceBusy      (busy),
        .sequenceDone      (done),
        .overrunFault      (overrun),
        .writeRejectFault  (wrrej)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [7:0]  code;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every transfer and done pulse against the scoreboard.
    logic       hold_pend = 1'b0;
    logic [7:0] hold_code = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (!valid) chk("code_zero_when_invalid", {24'd0, code}, 32'd0);
            if (hold_pend) begin
                chk("hold_valid", {31'd0, valid}, 32'd1);
                chk("hold_code", {24'd0, code}, {24'd0, hold_code});
            end
            hold_pend = valid && !ready && !abort;
            hold_code = code;
            if (valid && ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got code %0h at cycle %0d, required none", code, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", {31'd0, e.is_done}, 32'd0);
                    chk("event_code", {24'd0, code}, {24'd0, e.code});
                    chk("event_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", {31'd0, e.is_done}, 32'd1);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic push_ev(input logic [7:0] c, input int unsigned t);
        exp_t e;
        e.is_done = 1'b0; e.code = c; e.cyc = t;
        sb.push_back(e);
    endtask

    task automatic push_done(input int unsigned t);
        exp_t e;
        e.is_done = 1'b1; e.code = '0; e.cyc = t;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic write_entry(input logic [5:0] a, input logic [15:0] d, input logic [7:0] c);
        wstb = 1'b1; waddr = a; wdata = {d, c};
        tick();
        wstb = 1'b0;
    endtask

    task automatic start_seq(output int unsigned n);
        start = 1'b1;
        n = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        while ((sb.size() != 0 || busy) && n < 600) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (n >= 600) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending, required 0", name, sb.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"}, {31'd0, valid}, 32'd0);
        chk({name, "_code"}, {24'd0, code}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_done"}, {31'd0, done}, 32'd0);
        chk({name, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({name, "_wrrej"}, {31'd0, wrrej}, 32'd0);
    endtask

    initial begin
        int unsigned n;

        // Reset state, both during and right after reset.
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        write_entry(6'd0, 16'd5, 8'h10);
        write_entry(6'd1, 16'd0, 8'h20);
        write_entry(6'd2, 16'd0, 8'h00);

        // Basic playback, ready always high.
        ready = 1'b1;
        start_seq(n);
        push_ev(8'h10, n + 8);
        push_ev(8'h20, n + 11);
        push_done(n + 13);
        chk("busy_in_run", {31'd0, busy}, 32'd1);
        wait_idle("basic");
        chk("overrun_after_basic", {31'd0, overrun}, 32'd0);

        // Back-pressure: 0x10 held 5 cycles, rest shifted by 4.
        ready = 1'b0;
        start_seq(n);
        push_ev(8'h10, n + 12);
        push_ev(8'h20, n + 15);
        push_done(n + 17);
        wait_until(n + 12);
        ready = 1'b1;
        wait_idle("backpressure");

        // Start while in DELAY, then start with a same-cycle clear.
        start_seq(n);
        push_ev(8'h10, n + 8);
        push_ev(8'h20, n + 11);
        push_done(n + 13);
        wait_until(n + 4);
        start = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        start = 1'b0;
        clr = 1'b0;
        wait_idle("overrun");
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);

        // Abort during EMIT, then restart from address 0.
        ready = 1'b0;
        start_seq(n);
        wait_until(n + 9);
        chk("abort_pre_valid", {31'd0, valid}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_code", {24'd0, code}, 32'd0);
        tick();
        ready = 1'b1;
        start_seq(n);
        push_ev(8'h10, n + 8);
        push_ev(8'h20, n + 11);
        push_done(n + 13);
        wait_idle("restart");

        // Table write while busy is dropped.
        start_seq(n);
        push_ev(8'h10, n + 8);
        push_ev(8'h20, n + 11);
        push_done(n + 13);
        wait_until(n + 4);
        write_entry(6'd1, 16'd0, 8'h55);
        wait_idle("write_reject");
        chk("wrrej_set", {31'd0, wrrej}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("wrrej_cleared", {31'd0, wrrej}, 32'd0);

        // Full table, delay 0: implicit end after entry 63.
        for (int i = 0; i < 64; i++) write_entry(6'(i), 16'd0, 8'(i + 1));
        start_seq(n);
        for (int i = 0; i < 64; i++) push_ev(8'(i + 1), n + 3 + 3 * i);
        push_done(n + 193);
        wait_idle("full_table");

        // Reset mid-run: outputs drop immediately.
        start_seq(n);
        for (int i = 0; i < 16; i++) push_ev(8'(i + 1), n + 3 + 3 * i);
        wait_until(n + 50);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        chk("midrun_sb_drained", sb.size(), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Table survives reset.
        start_seq(n);
        for (int i = 0; i < 64; i++) push_ev(8'(i + 1), n + 3 + 3 * i);
        push_done(n + 193);
        wait_idle("after_reset");
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
